// File: rtl/pool_sequencer.sv
// rtl/pool_sequencer.sv - drives one pooler across C channel maps, fetching pixels and writing pooled results.
// Optional stall/starve performance counter when POOL_SEQ_PERF_EN is defined.
module pool_sequencer #(
    parameter int M         = 12,
    parameter int P         = 3,
    parameter int N         = 16,
    parameter int CW        = 8,
    parameter int AW        = 16,
    parameter int DRAIN_MAX = 64
) (
    input  logic          clk,
    input  logic          master_rst,
    input  logic          start,
    input  logic [CW-1:0] num_ch,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [N-1:0]  rd_data,
    output logic          pool_rst_n,
    output logic          pool_ce,
    output logic [N-1:0]  pool_data,
    input  logic [N-1:0]  pool_dout,
    input  logic          pool_valid,
    input  logic          pool_end,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [N-1:0]  wr_data,
    input  logic          wr_ready
`ifdef POOL_SEQ_PERF_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    localparam int MM = M * M;
    localparam int R  = (M / P) * (M / P);
    localparam int PW = $clog2(MM + 1);
    localparam int RW = $clog2(R + 1);
    localparam int DW = $clog2(DRAIN_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STREAM,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] num_ch_q;
    logic [CW-1:0] ch;
    logic [PW-1:0] pix;
    logic [RW-1:0] res;
    logic [DW-1:0] drain;
    logic          rd_pend;
    logic [N-1:0]  stg;
    logic          stg_vld;
    logic          out_pend;
    logic [N-1:0]  out_data;
    logic [AW-1:0] rd_base;
    logic [AW-1:0] wr_base;
    logic          err_q;
    logic          prst_q;

    logic          stall;
    logic          consume;
    logic          capture;
    logic          wr_done;
    logic          ch_last;
    logic          drain_timeout;
    logic [CW:0]   ch_inc;
    logic          unused_inputs;

    assign unused_inputs = pool_end;

    assign stall         = out_pend && !wr_ready;
    assign consume       = (state == S_STREAM) && pool_ce;
    assign capture       = pool_valid && pool_ce;
    assign wr_done       = out_pend && wr_ready;
    assign ch_inc        = {1'b0, ch} + (CW + 1)'(1);
    assign ch_last       = ch_inc >= {1'b0, num_ch_q};
    assign drain_timeout = (state == S_DRAIN) && (res != RW'(R)) && (drain == DW'(DRAIN_MAX - 1));

    always_comb begin
        pool_ce   = 1'b0;
        pool_data = '0;
        rd_en     = 1'b0;
        case (state)
            S_STREAM: begin
                pool_ce   = stg_vld && !stall;
                pool_data = stg;
                // A fetch is only issued when its data is guaranteed a free staging slot.
                rd_en     = (pix < PW'(MM)) && !rd_pend && (!stg_vld || (stg_vld && !stall));
            end
            S_DRAIN: begin
                pool_ce = !stall;
            end
            default: begin
                pool_ce = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = (num_ch == '0) ? S_DONE : S_CLR;
                end
            end
            S_CLR: begin
                state_n = S_STREAM;
            end
            S_STREAM: begin
                if ((pix == PW'(MM)) && !stg_vld && !rd_pend) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((res == RW'(R)) || (drain == DW'(DRAIN_MAX - 1))) begin
                    state_n = S_NEXT;
                end
            end
            S_NEXT: begin
                if (!out_pend) begin
                    state_n = ch_last ? S_DONE : S_CLR;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!master_rst) begin
            state    <= S_IDLE;
            num_ch_q <= '0;
            ch       <= '0;
            pix      <= '0;
            res      <= '0;
            drain    <= '0;
            rd_pend  <= 1'b0;
            stg      <= '0;
            stg_vld  <= 1'b0;
            out_pend <= 1'b0;
            out_data <= '0;
            rd_base  <= '0;
            wr_base  <= '0;
            err_q    <= 1'b0;
            prst_q   <= 1'b0;
        end else begin
            state   <= state_n;
            prst_q  <= 1'b1;
            rd_pend <= rd_en;

            if (rd_en) begin
                pix <= pix + PW'(1);
            end

            if (rd_pend) begin
                stg     <= rd_data;
                stg_vld <= 1'b1;
            end else if (consume) begin
                stg_vld <= 1'b0;
            end

            // A same-cycle capture and write completion keeps the register full with new data.
            if (capture) begin
                out_data <= pool_dout;
                out_pend <= 1'b1;
            end else if (wr_done) begin
                out_pend <= 1'b0;
            end

            if (wr_done) begin
                res <= res + RW'(1);
            end

            if (state == S_DRAIN) begin
                drain <= drain + DW'(1);
            end

            if (drain_timeout) begin
                err_q <= 1'b1;
            end

            if ((state == S_IDLE) && start) begin
                num_ch_q <= num_ch;
                err_q    <= 1'b0;
                ch       <= '0;
                rd_base  <= '0;
                wr_base  <= '0;
            end

            if (state == S_CLR) begin
                pix   <= '0;
                res   <= '0;
                drain <= '0;
            end

            if ((state == S_NEXT) && !out_pend) begin
                ch      <= ch + CW'(1);
                rd_base <= rd_base + AW'(MM);
                wr_base <= wr_base + AW'(R);
            end
        end
    end

    assign busy       = (state == S_CLR) || (state == S_STREAM) || (state == S_DRAIN) || (state == S_NEXT);
    assign done       = (state == S_DONE);
    assign err        = err_q;
    assign rd_addr    = rd_base + AW'(pix);
    assign wr_addr    = wr_base + AW'(res);
    assign wr_en      = out_pend;
    assign wr_data    = out_data;
    assign pool_rst_n = prst_q && (state != S_CLR);

`ifdef POOL_SEQ_PERF_EN
    logic [31:0] stall_q;
    logic        starve;

    assign starve = (state == S_STREAM) && !stg_vld;

    always_ff @(posedge clk) begin
        if (!master_rst) begin
            stall_q <= '0;
        end else if ((state == S_IDLE) && start) begin
            stall_q <= '0;
        end else if (((state == S_STREAM) || (state == S_DRAIN)) && (stall || starve)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
